// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per clock: shift-add for mult/multu, restoring
// shift-subtract for div/divu. Signed operands run as magnitudes and are
// sign-corrected in a final FIX cycle.
// Optional feature: define MDU_DIV0_FLAG_EN to add the registered div0_o flag.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic             div0_o
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               state_q;
    logic                 div_q;     // 1: divide, 0: multiply
    logic                 sa_q, sb_q; // operand signs (always 0 for unsigned ops)
    logic [WIDTH-1:0]     mb_q;      // |b|
    logic [2*WIDTH-1:0]   acc_q;     // mult: {upper, multiplier}; div: {rem, quo}
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 busy_q, done_q;
`ifdef MDU_DIV0_FLAG_EN
    logic                 div0_q;
`endif

    // Operand magnitudes at launch; op_i[0]=0 selects the signed forms.
    logic                 sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b;
    always_comb begin
        sgn_op = ~op_i[0];
        a_neg  = sgn_op & a_i[WIDTH-1];
        b_neg  = sgn_op & b_i[WIDTH-1];
        mag_a  = a_neg ? -a_i : a_i;
        mag_b  = b_neg ? -b_i : b_i;
    end

    // One iteration of each algorithm, computed from the accumulator.
    logic [WIDTH:0]       add_sum, shl, dif;
    logic [2*WIDTH-1:0]   mul_next, div_next;
    always_comb begin
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mb_q};
        mul_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};
        // Partial remainder < |b|, so dif[WIDTH] is the borrow of shl - |b|.
        shl      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        dif      = shl - {1'b0, mb_q};
        div_next = dif[WIDTH] ? {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // Sign correction applied at the FIX edge.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic                 b_zero;
    always_comb begin
        b_zero   = (mb_q == '0);
        prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        // With |b|=0 the remainder walks out as |a|, so sign-fixing it yields a.
        rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Control FSM, working datapath and architectural HI/LO.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            mb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            div0_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        div_q   <= op_i[1];
                        sa_q    <= a_neg;
                        sb_q    <= b_neg;
                        mb_q    <= mag_b;
                        acc_q   <= {{WIDTH{1'b0}}, mag_a};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        // mthi/mtlo only when no operation is launched
                        if (hi_we_i) hi_q <= wd_i;
                        if (lo_we_i) lo_q <= wd_i;
                    end
                end
                S_RUN: begin
                    acc_q <= div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (div_q) begin
                        lo_q <= b_zero ? {WIDTH{1'b1}} : quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
`ifdef MDU_DIV0_FLAG_EN
                    div0_q  <= div_q & b_zero;
`endif
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
`ifdef MDU_DIV0_FLAG_EN
    assign div0_o = div0_q;
`endif
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed testbench for mdu_hilo (WIDTH=32).
module tb_mdu_hilo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wd = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MDU_DIV0_FLAG_EN
    logic        div0;
`endif

    int checks = 0;
    int errors = 0;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .hi_we_i (hi_we),
        .lo_we_i (lo_we),
        .wd_i    (wd),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
`ifdef MDU_DIV0_FLAG_EN
        ,
        .div0_o  (div0)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one start pulse; returns at the negedge right after the start edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
    endtask

    // Counts edges after the start edge until done (bounded), and busy samples.
    task automatic run_to_done(output int lat, output int bc);
        lat = 0; bc = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", lo); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_multu();
        int lat, bc;
        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_to_done(lat, bc);
        checks++; if (lat != 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
        checks++; if (bc != 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult_div_signed();
        int lat, bc;
        launch(2'b00, 32'hFFFFFFFD, 32'd7);
        run_to_done(lat, bc);
        checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        launch(2'b10, 32'hFFFFFFF9, 32'd2);
        run_to_done(lat, bc);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        run_to_done(lat, bc);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
    endtask

    // HI=0, LO=0x80000000 on entry.
    task automatic test_start_ignored();
        int dn, first;
        dn = 0; first = -1;
        launch(2'b11, 32'd100, 32'd7);
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) begin dn++; if (first < 0) first = i; end
            if (i == 20) begin
                checks++;
                if (hi !== 32'h0 || lo !== 32'h80000000) begin
                    errors++; $display("FAIL hilo_stable_in_run: got hi=%h lo=%h want 00000000/80000000", hi, lo);
                end
            end
            start = (i == 9);
            if (i == 9) begin op = 2'b00; a = 32'd50; b = 32'd3; end
            @(negedge clk);
        end
        checks++; if (first != 33) begin errors++; $display("FAIL ignore_latency: got %0d want 33", first); end
        checks++; if (dn != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dn); end
        checks++; if (lo !== 32'h0000000E) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL divu_hi: got %h want 00000002", hi); end
    endtask

    task automatic test_div0();
        int lat, bc;
        launch(2'b10, 32'h12345678, 32'h0);
        run_to_done(lat, bc);
        checks++; if (lat != 33) begin errors++; $display("FAIL div0_latency: got %0d want 33", lat); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL div0_hi: got %h want 12345678", hi); end
`ifdef MDU_DIV0_FLAG_EN
        checks++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_flag_set: got %b want 1", div0); end
`endif
        launch(2'b10, 32'hFFFFFFF0, 32'h0);
        run_to_done(lat, bc);
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_neg_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'hFFFFFFF0) begin errors++; $display("FAIL div0_neg_hi: got %h want fffffff0", hi); end
        launch(2'b11, 32'd8, 32'd2);
        run_to_done(lat, bc);
        checks++; if (lo !== 32'd4) begin errors++; $display("FAIL divu8_lo: got %h want 00000004", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL divu8_hi: got %h want 00000000", hi); end
`ifdef MDU_DIV0_FLAG_EN
        checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL div0_flag_clear: got %b want 0", div0); end
`endif
    endtask

    // HI=0, LO=4 on entry.
    task automatic test_hilo_write();
        int first;
        first = -1;
        @(negedge clk);
        hi_we = 1'b1; wd = 32'hAAAA5555;
        @(negedge clk);
        hi_we = 1'b0;
        checks++; if (hi !== 32'hAAAA5555) begin errors++; $display("FAIL mthi_hi: got %h want aaaa5555", hi); end
        checks++; if (lo !== 32'd4) begin errors++; $display("FAIL mthi_lo_kept: got %h want 00000004", lo); end
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h11112222;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'h11112222 || lo !== 32'h11112222) begin
            errors++; $display("FAIL mthi_mtlo_both: got hi=%h lo=%h want 11112222/11112222", hi, lo);
        end
        // start and hi_we on the same edge: start wins
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5; hi_we = 1'b1; wd = 32'hDEAD0000;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        checks++; if (hi !== 32'h11112222) begin errors++; $display("FAIL start_beats_hi_we: got %h want 11112222", hi); end
        for (int i = 0; i < 50; i++) begin
            if (done === 1'b1 && first < 0) first = i;
            if (i == 6) begin
                checks++; if (lo !== 32'h11112222) begin errors++; $display("FAIL mtlo_while_busy: got %h want 11112222", lo); end
            end
            lo_we = (i == 5);
            if (i == 5) wd = 32'hCAFEF00D;
            @(negedge clk);
        end
        checks++; if (first != 33) begin errors++; $display("FAIL busy_write_latency: got %0d want 33", first); end
        checks++; if (lo !== 32'd15 || hi !== 32'd0) begin
            errors++; $display("FAIL busy_write_result: got hi=%h lo=%h want 00000000/0000000f", hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        launch(2'b00, 32'd7, 32'd9);
        for (int i = 0; i < 15; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0/0", busy, done);
        end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL midreset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        launch(2'b01, 32'd3, 32'd5);
        run_to_done(lat, bc);
        checks++; if (lat != 33) begin errors++; $display("FAIL post_reset_latency: got %0d want 33", lat); end
        checks++; if (lo !== 32'd15 || hi !== 32'd0) begin
            errors++; $display("FAIL post_reset_result: got hi=%h lo=%h want 00000000/0000000f", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_div_signed();
        test_start_ignored();
        test_div0();
        test_hilo_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Sits beside the ALU and consumes the register-file read operands (RD1 as a, RD2 as b).
- Executes mult, multu, div and divu over multiple cycles; the core stalls on busy.
- Core reads results through hi/lo (mfhi/mflo) and writes them through hi_we/lo_we (mthi/mtlo).

Parameters:
WIDTH, 32, operand width; iteration count = WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  launch operation; sampled at posedge when busy=0
op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
hi_we  input  1  mthi: HI <= wd
lo_we  input  1  mtlo: LO <= wd
wd  input  WIDTH  write data for hi_we/lo_we
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO hold the new result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any time including mid-operation): state IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Partial results are discarded.
- FSM states:
  - IDLE: start=1 at edge E0 -> RUN. On that edge, latch op, sign flags and |a|, |b| (magnitudes for signed ops, raw values for unsigned). Clear accumulator; counter=0.
  - RUN: one radix-2 step per edge, E1..E_WIDTH.
    - Multiply: shift-add into a 2*WIDTH product register.
    - Divide: restoring shift-subtract; quotient bit = no-borrow.
    - counter increments each step; after step WIDTH -> FIX.
  - FIX (edge E_WIDTH+1): apply sign correction.
    - Product: negated if sign(a) != sign(b).
    - Quotient: negated if sign(a) != sign(b).
    - Remainder: takes the sign of the dividend.
    - Write HI/LO: mult -> HI=product[2W-1:W], LO=product[W-1:0]; div -> LO=quotient, HI=remainder. Then -> IDLE.
- Timing:
  - busy=1 in the cycles after E0 through E_WIDTH+1; busy=0 after the FIX edge.
  - done=1 for exactly the cycle after the FIX edge.
  - Total latency = WIDTH+1 edges after the start edge (33 for WIDTH=32).
- Arithmetic rules:
  - All arithmetic is modulo 2^WIDTH per half.
  - Signed div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - Divide by zero (b=0, div or divu) -> LO=all ones, HI=a. Same latency; no exception.
- start while busy=1: ignored; no queuing.
- hi_we/lo_we:
  - While busy=1: ignored.
  - At the same edge as an accepted start: ignored (start wins).
  - Otherwise, write at the edge; both may be asserted together.
- FIX-edge write takes priority over any concurrent hi_we/lo_we (these are blocked by busy=1 anyway).
- hi/lo are the registers driven directly, not the working accumulators; they do not change during RUN.

Optional Feature:
- Macro MDU_DIV0_FLAG_EN.
- When defined:
  - Adds output port div0 (1 bit). div0 is registered: set at the FIX edge of a divide with b=0, otherwise cleared at that edge, and cleared by reset.
  - div0 is valid together with done.
- When undefined: no div0 port. Divide-by-zero results are identical (LO=all ones, HI=a).

Test Plan:
- multu a=0xFFFFFFFF, b=0xFFFFFFFF, start 1 cycle -> busy for 33 cycles; done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- mult a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then div a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu a=100, b=7 -> LO=0x0000000E, HI=0x00000002. Re-pulse start with different operands at cycle 10 -> ignored; result unchanged; done only once.
- div a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678. With MDU_DIV0_FLAG_EN: div0=1. A following divu 8/2 -> div0=0, LO=4, HI=0.
- hi_we=1, wd=0xAAAA5555 in IDLE -> HI=0xAAAA5555 next cycle, LO unchanged. lo_we during busy -> LO not modified until FIX writes the result.
- Start mult, assert reset at cycle 15 -> busy=0, done=0, hi=lo=0 immediately. After release, a new multu 3*5 -> LO=15, HI=0, 33 cycles after start.
